pwm_fade_controller: RTL
========================

Name: pwm_fade_controller

Overview:
Sequencer for one 8-bit PWM channel on the DE2 platform. Contains its own tick prescaler and 8-bit phase counter. Drives the PWM duty either from a static configuration value or from an autonomous breathing ramp (up, hold at top, down, hold at bottom). Duty changes are applied only on PWM period boundaries, so the output never produces glitched periods.

Parameters:
PRESCALE, 100000, clock cycles per PWM tick; must be ≥ 2; 50 MHz / 100000 = 500 Hz tick.
DUTY_STEP, 8'd1, duty increment/decrement applied per PWM period while ramping.

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  run control; low forces IDLE
mode  input  1  0 = static duty from duty_cfg, 1 = breathing ramp
duty_cfg  input  8  static duty value, 0..255
hold_periods  input  8  extra periods to dwell at 255 and at 0 in breathing mode
pwm_out  output  1  PWM waveform
duty  output  8  duty currently applied
period_start  output  1  one-clock pulse when the phase counter wraps to 0
cycle_done  output  1  one-clock pulse when a full breathing cycle completes
state  output  3  FSM state: IDLE=0, STATIC=1, UP=2, TOP_HOLD=3, DOWN=4, BOT_HOLD=5

Behaviour:
- Reset, and enable low: all outputs and counters are 0 and state is IDLE. Reset acts asynchronously. Deasserting enable forces IDLE with a full clear on the next clock edge.
- Prescaler: a counter runs 0..PRESCALE-1 while not IDLE. The internal tick is high for one clock when the count equals PRESCALE-1, and the counter returns to 0 on that clock.
- Phase counter: 8 bits, advances on each tick, runs 0..254, and wraps from 254 to 0. The period is 255 ticks, which is 255*PRESCALE clocks.
- period_start is registered. It is high during the clock after the edge on which the phase becomes 0.
- Boundary event: the same edge that wraps the phase to 0. All duty and FSM updates happen only on a boundary event, except for leaving or entering IDLE.
- pwm_out is combinational and equals (phase < duty) while not IDLE, otherwise 0.
  - duty=0 gives a constant low.
  - duty=255 gives a constant high, because phase never reaches 255.
- Leaving IDLE (enable high seen while in IDLE): on the next edge, go to STATIC if mode=0 or UP if mode=1. The phase counter and prescaler start from 0.
  - STATIC: duty loads duty_cfg on that edge.
  - UP: duty loads 0 on that edge.
- STATIC: duty loads duty_cfg at each boundary. A mode=1 seen at a boundary moves to UP with duty 0.
- UP: at each boundary, duty = min(duty+DUTY_STEP, 255), using 9-bit saturating arithmetic. When the result is 255, go to TOP_HOLD and load the hold counter with hold_periods.
- TOP_HOLD: at each boundary, if the hold counter is 0, go to DOWN and set duty = 255 - DUTY_STEP (saturating at 0). Otherwise decrement the hold counter. Duty therefore stays at 255 for hold_periods+1 periods in total.
- DOWN: at each boundary, duty = max(duty - DUTY_STEP, 0). When the result is 0, go to BOT_HOLD and load the hold counter with hold_periods.
- BOT_HOLD: at each boundary, if the hold counter is 0, go to UP, set duty = min(DUTY_STEP, 255), and pulse cycle_done during the following clock. Otherwise decrement the hold counter.
- Mode change in breathing states: mode=0 seen at a boundary moves to STATIC with duty = duty_cfg. The ramp position is discarded.
- Input sampling: duty_cfg, mode and hold_periods are sampled only at boundaries (or on the edge leaving IDLE). Mid-period changes have no effect until then.
- Latency: a duty change is visible on pwm_out from phase 0 of the new period.

Test Plan:
- Reset mid-run: PRESCALE=2, mode=1, reset_n pulsed low mid-ramp → duty=0, pwm_out=0, state=0 immediately, without waiting for a clock. After release with enable=1, state=2 and duty=0 after one edge.
- Static duty: PRESCALE=2, mode=0, duty_cfg=64 → pwm_out high 128 clocks and low 382 clocks per 510-clock period. period_start spacing is exactly 510 clocks. Changing duty_cfg to 192 mid-period takes effect only after the next period_start.
- Breathing sequence: DUTY_STEP=64, hold_periods=2 → per-period duty is 0, 64, 128, 192, 255, 255, 255, 191, 127, 63, 0, 0, 0, 64. cycle_done pulses once, at the 0→64 transition.
- Extremes: duty=255 → pwm_out constantly high across the wrap. duty=0 → constantly low, with no 1-clock glitch at the boundary.
- Enable drop: enable low during DOWN → IDLE with all outputs 0 on the next edge. Re-enable with mode=1 → restart in UP with duty=0, and the phase restarts at 0.
- Mode switch: during UP with duty=128, mode set to 0 with duty_cfg=32 → at the next boundary state=1 and duty=32. No change occurs before that boundary.

Source files
------------

// File: rtl/pwm_fade_controller.sv
// Single-channel 8-bit PWM with static or breathing duty; duty changes only on period wrap.
module pwm_fade_controller #(
  parameter int unsigned PRESCALE  = 100000,
  parameter logic [7:0]  DUTY_STEP = 8'd1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       mode,
  input  logic [7:0] duty_cfg,
  input  logic [7:0] hold_periods,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic       period_start,
  output logic       cycle_done,
  output logic [2:0] state
);

  localparam int unsigned PRE_W       = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [7:0]  PHASE_LAST  = 8'd254;
  localparam logic [7:0]  DUTY_MAX    = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STATIC   = 3'd1,
    S_UP       = 3'd2,
    S_TOP_HOLD = 3'd3,
    S_DOWN     = 3'd4,
    S_BOT_HOLD = 3'd5
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PRE_W-1:0] presc_q;
  logic [7:0]       phase_q;
  logic [7:0]       hold_q;
  logic [7:0]       hold_d;
  logic [7:0]       duty_d;
  logic             cycle_done_d;
  logic             running;
  logic             tick;
  logic             boundary;
  logic [8:0]       up_sum;
  logic [7:0]       up_sat;
  logic [7:0]       dn_sat;
  logic [7:0]       top_exit;

  assign running  = (state_q != S_IDLE);
  assign tick     = running && (presc_q == PRE_LAST);
  assign boundary = tick && (phase_q == PHASE_LAST);
  assign state    = state_q;
  assign pwm_out  = running && (phase_q < duty);

  // Saturating ramp arithmetic
  assign up_sum   = {1'b0, duty} + {1'b0, DUTY_STEP};
  assign up_sat   = (up_sum >= 9'd255) ? DUTY_MAX : up_sum[7:0];
  assign dn_sat   = (duty > DUTY_STEP) ? (duty - DUTY_STEP) : 8'd0;
  assign top_exit = DUTY_MAX - DUTY_STEP;

  // Tick prescaler, cleared while idle or disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (!enable || !running || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Phase counter 0..254, advancing once per tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 8'd0;
    end else if (!enable || !running || boundary) begin
      phase_q <= 8'd0;
    end else if (tick) begin
      phase_q <= phase_q + 8'd1;
    end
  end

  // Period-start pulse, high the clock after the phase wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= enable && boundary;
    end
  end

  // FSM, duty and hold-counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      duty       <= 8'd0;
      hold_q     <= 8'd0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty       <= duty_d;
      hold_q     <= hold_d;
      cycle_done <= cycle_done_d;
    end
  end

  // Next state and duty; everything except idle entry/exit waits for a boundary
  always_comb begin
    state_d      = state_q;
    duty_d       = duty;
    hold_d       = hold_q;
    cycle_done_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      duty_d  = 8'd0;
      hold_d  = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hold_d = 8'd0;
          if (mode) begin
            state_d = S_UP;
            duty_d  = 8'd0;
          end else begin
            state_d = S_STATIC;
            duty_d  = duty_cfg;
          end
        end
        default: begin
          if (boundary) begin
            if (!mode) begin
              state_d = S_STATIC;
              duty_d  = duty_cfg;
            end else begin
              case (state_q)
                S_STATIC: begin
                  state_d = S_UP;
                  duty_d  = 8'd0;
                end
                S_UP: begin
                  duty_d = up_sat;
                  if (up_sat == DUTY_MAX) begin
                    state_d = S_TOP_HOLD;
                    hold_d  = hold_periods;
                  end
                end
                S_TOP_HOLD: begin
                  if (hold_q == 8'd0) begin
                    state_d = S_DOWN;
                    duty_d  = top_exit;
                  end else begin
                    hold_d = hold_q - 8'd1;
                  end
                end
                S_DOWN: begin
                  duty_d = dn_sat;
                  if (dn_sat == 8'd0) begin
                    state_d = S_BOT_HOLD;
                    hold_d  = hold_periods;
                  end
                end
                S_BOT_HOLD: begin
                  if (hold_q == 8'd0) begin
                    state_d      = S_UP;
                    duty_d       = DUTY_STEP;
                    cycle_done_d = 1'b1;
                  end else begin
                    hold_d = hold_q - 8'd1;
                  end
                end
                default: begin
                  state_d = S_IDLE;
                  duty_d  = 8'd0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
